// File: rtl/tdc_wrapper_pkg.sv
// Shared types for the TDC capture block: FSM states, sample-count
// encoding and the helper that turns that encoding into a last-sample index.
package tdc_wrapper_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL0 = 3'd1,
    FILL1 = 3'd2,
    ACCUM = 3'd3,
    DONE  = 3'd4
  } tdc_state_e;

  typedef enum logic [1:0] {
    NSEL_1 = 2'd0,
    NSEL_2 = 2'd1,
    NSEL_4 = 2'd2,
    NSEL_8 = 2'd3
  } tdc_nsel_e;

  localparam int unsigned CNT_W = 3;

  // Index of the final sample (N-1) for a given samples-per-measurement code.
  function automatic logic [CNT_W-1:0] nsel_last(input tdc_nsel_e sel);
    logic [CNT_W-1:0] last_v;
    case (sel)
      NSEL_1:  last_v = 3'd0;
      NSEL_2:  last_v = 3'd1;
      NSEL_4:  last_v = 3'd3;
      NSEL_8:  last_v = 3'd7;
      default: last_v = 3'd0;
    endcase
    return last_v;
  endfunction

endpackage

// File: rtl/tt_tdc_popcount.sv
// Combinational tap evaluator: counts ones in a synchronized delay-line
// snapshot and flags non-thermometer (bubble) and saturated (all ones) codes.
module tt_tdc_popcount
  import tdc_wrapper_pkg::*;
#(
  parameter int len_pop_out = 6,
  parameter int dl_len      = 2**len_pop_out
) (
  input  logic [dl_len-1:0]    taps,
  output logic [len_pop_out:0] count,
  output logic                 bubble,
  output logic                 all_ones
);

  // Population count plus code-quality flags for one snapshot.
  always_comb begin
    count = '0;
    for (int i = 0; i < dl_len; i++) begin
      count = count + {{len_pop_out{1'b0}}, taps[i]};
    end
    // A one above a zero means the thermometer code has a hole in it.
    bubble   = |(taps[dl_len-1:1] & ~taps[dl_len-2:0]);
    all_ones = &taps;
  end

endmodule

// File: rtl/tt_tdc_capture.sv
// TDC capture: synchronizes the delay-line taps, then on arm accumulates
// the popcount of N consecutive samples and offers the sum with a
// valid/ready handshake, together with bubble and overflow flags.
module tt_tdc_capture
  import tdc_wrapper_pkg::*;
#(
  parameter int len_pop_out = 6,
  parameter int dl_len      = 2**len_pop_out,
  parameter int acc_w       = len_pop_out + 4
) (
  input  logic              clk_capture,
  input  logic              rst_n,
  input  logic              en,
  input  logic              arm,
  input  logic [1:0]        n_sel,
  input  logic [dl_len-1:0] dl_tap,
  input  logic              out_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [acc_w-1:0]  out_sum,
  output logic              out_bubble,
  output logic              out_ovf
);

  (* keep = "true" *) logic [dl_len-1:0] sync1_r;
  (* keep = "true" *) logic [dl_len-1:0] sync2_r;

  tdc_state_e          state_r;
  logic                busy_r;
  logic                valid_r;
  logic [acc_w-1:0]    acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    last_r;
  logic                bubble_r;
  logic                ovf_r;

  logic [len_pop_out:0] pop_s;
  logic                 pop_bubble_s;
  logic                 pop_all_ones_s;
  logic [acc_w-1:0]     pop_ext_s;

  // Free-running two-flop synchronizer for the asynchronous taps.
  always_ff @(posedge clk_capture or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= dl_tap;
      sync2_r <= sync1_r;
    end
  end

  tt_tdc_popcount #(
    .len_pop_out (len_pop_out),
    .dl_len      (dl_len)
  ) u_popcount (
    .taps     (sync2_r),
    .count    (pop_s),
    .bubble   (pop_bubble_s),
    .all_ones (pop_all_ones_s)
  );

  assign pop_ext_s = {{(acc_w-len_pop_out-1){1'b0}}, pop_s};

  // Measurement FSM with accumulator and registered handshake outputs.
  // Dropping en aborts anything except a pending result in DONE.
  always_ff @(posedge clk_capture or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      acc_r    <= '0;
      cnt_r    <= '0;
      last_r   <= '0;
      bubble_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (!en && (state_r != DONE) && (state_r != IDLE)) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      acc_r    <= '0;
      cnt_r    <= '0;
      bubble_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en && arm) begin
            state_r  <= FILL0;
            busy_r   <= 1'b1;
            acc_r    <= '0;
            cnt_r    <= '0;
            bubble_r <= 1'b0;
            ovf_r    <= 1'b0;
            last_r   <= nsel_last(tdc_nsel_e'(n_sel));
          end
        end
        FILL0: state_r <= FILL1;
        FILL1: state_r <= ACCUM;
        ACCUM: begin
          acc_r    <= acc_r + pop_ext_s;
          cnt_r    <= cnt_r + 3'd1;
          bubble_r <= bubble_r | pop_bubble_s;
          ovf_r    <= ovf_r | pop_all_ones_s;
          if (cnt_r == last_r) begin
            state_r <= DONE;
            valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign out_valid  = valid_r;
  assign out_sum    = acc_r;
  assign out_bubble = bubble_r;
  assign out_ovf    = ovf_r;

endmodule

// File: tb/tb_tt_tdc_capture.sv
// Directed self-checking bench for tt_tdc_capture with default parameters.
module tb_tt_tdc_capture;

  logic        clk_capture;
  logic        rst_n;
  logic        en;
  logic        arm;
  logic [1:0]  n_sel;
  logic [63:0] dl_tap;
  logic        out_ready;
  logic        busy;
  logic        out_valid;
  logic [9:0]  out_sum;
  logic        out_bubble;
  logic        out_ovf;

  int checks_cnt = 0;
  int errors_cnt = 0;

  tt_tdc_capture dut (
    .clk_capture (clk_capture),
    .rst_n       (rst_n),
    .en          (en),
    .arm         (arm),
    .n_sel       (n_sel),
    .dl_tap      (dl_tap),
    .out_ready   (out_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_sum     (out_sum),
    .out_bubble  (out_bubble),
    .out_ovf     (out_ovf)
  );

  initial clk_capture = 1'b0;
  always #5 clk_capture = ~clk_capture;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_capture);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"},   {31'd0, busy},       32'd0);
    check({tag, " valid"},  {31'd0, out_valid},  32'd0);
    check({tag, " sum"},    {22'd0, out_sum},    32'd0);
    check({tag, " bubble"}, {31'd0, out_bubble}, 32'd0);
    check({tag, " ovf"},    {31'd0, out_ovf},    32'd0);
  endtask

  // One full measurement with out_ready held high throughout.
  task automatic run_meas(input string tag, input logic [1:0] ns, input logic [63:0] tap,
                          input int exp_sum, input logic exp_bub, input logic exp_ovf);
    int lat;
    int nsamp;
    nsamp     = 1 << ns;
    dl_tap    = tap;
    en        = 1'b1;
    out_ready = 1'b1;
    arm       = 1'b0;
    repeat (3) tick();
    n_sel = ns;
    arm   = 1'b1;
    tick();
    arm = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      tick();
      if (out_valid) lat = k;
    end
    check({tag, " latency"}, lat, nsamp + 2);
    check({tag, " sum"},    {22'd0, out_sum},    exp_sum);
    check({tag, " bubble"}, {31'd0, out_bubble}, {31'd0, exp_bub});
    check({tag, " ovf"},    {31'd0, out_ovf},    {31'd0, exp_ovf});
    tick();
    check({tag, " drop"},   {31'd0, out_valid},  32'd0);
    check({tag, " idle"},   {31'd0, busy},       32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    en        = 1'b0;
    arm       = 1'b0;
    n_sel     = 2'd0;
    dl_tap    = 64'd0;
    out_ready = 1'b0;
    #3;
    check_idle_zero("reset");
    #9;
    rst_n = 1'b1;
    tick();
    check_idle_zero("post_reset");

    run_meas("n1_ff",    2'd0, 64'h0000_0000_0000_00FF,   8, 1'b0, 1'b0);
    run_meas("n8_ffff",  2'd3, 64'h0000_0000_0000_FFFF, 128, 1'b0, 1'b0);
    run_meas("n8_ones",  2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 512, 1'b0, 1'b1);
    run_meas("n2_hole",  2'd1, 64'h0000_0000_0000_00F7,  14, 1'b1, 1'b0);
    run_meas("n1_hole",  2'd0, 64'h0000_0000_0000_00F7,   7, 1'b1, 1'b0);
    run_meas("n4_three", 2'd2, 64'h0000_0000_0000_0007,  12, 1'b0, 1'b0);

    // Back-pressure in DONE: result held, second arm and en=0 ignored.
    dl_tap    = 64'h0000_0000_0000_00FF;
    out_ready = 1'b0;
    n_sel     = 2'd0;
    repeat (3) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      tick();
      if (out_valid) lat = k;
    end
    check("hold latency", lat, 3);
    dl_tap = 64'hFFFF_FFFF_FFFF_FFFF;
    n_sel  = 2'd3;
    for (int k = 0; k < 5; k++) begin
      arm = (k == 1);
      en  = (k < 3);
      tick();
      check("hold valid", {31'd0, out_valid}, 32'd1);
      check("hold sum",   {22'd0, out_sum},   32'd8);
      check("hold ovf",   {31'd0, out_ovf},   32'd0);
    end
    arm       = 1'b0;
    out_ready = 1'b1;
    tick();
    check("hold release valid", {31'd0, out_valid}, 32'd0);
    check("hold release busy",  {31'd0, busy},      32'd0);
    tick();
    check("arm ignored busy",   {31'd0, busy},      32'd0);

    // Reset asserted mid-ACCUM, then arm accepted on the first edge after release.
    en     = 1'b1;
    n_sel  = 2'd3;
    dl_tap = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (4) tick();
    check("accum busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("rst_mid");
    dl_tap = 64'h0000_0000_0000_00FF;
    n_sel  = 2'd0;
    arm    = 1'b1;
    @(negedge clk_capture);
    rst_n = 1'b1;
    tick();
    arm = 1'b0;
    check("rel arm busy", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      tick();
      if (out_valid) lat = k;
    end
    check("rel latency", lat, 3);
    check("rel sum", {22'd0, out_sum}, 32'd8);
    tick();
    check("rel drop", {31'd0, out_valid}, 32'd0);

    // en dropped while in FILL1 aborts the measurement.
    n_sel  = 2'd3;
    dl_tap = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    en = 1'b0;
    tick();
    check_idle_zero("abort");
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("abort no valid", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/tt_tdc_capture.md
TT_TDC_CAPTURE -- requirements
Module: tt_tdc_capture

Interface
REQ-001 The block SHALL have parameter len_pop_out, default 6, meaning the log2 of the delay-line tap count.
REQ-002 The block SHALL have parameter dl_len, default 2**len_pop_out, meaning the number of delay-line taps.
REQ-003 The block SHALL have parameter acc_w, default len_pop_out+4, meaning the accumulator and result width.
REQ-004 The block SHALL have port clk_capture, input, width 1, the only clock, rising-edge.
REQ-005 The block SHALL have port rst_n, input, width 1, asynchronous active-low reset.
REQ-006 The block SHALL have port en, input, width 1, the block enable.
REQ-007 The block SHALL have port arm, input, width 1, a request to start one measurement.
REQ-008 The block SHALL have port n_sel, input, width 2, the samples per measurement: 0 -> 1, 1 -> 2, 2 -> 4, 3 -> 8.
REQ-009 The block SHALL have port dl_tap, input, width dl_len, the asynchronous delay-line taps, with tap 0 nearest the launch point.
REQ-010 The block SHALL have port out_ready, input, width 1, the consumer ready signal.
REQ-011 The block SHALL have port busy, output, width 1, high whenever the state is not IDLE.
REQ-012 The block SHALL have port out_valid, output, width 1, meaning a result is available.
REQ-013 The block SHALL have port out_sum, output, width acc_w, the sum of tap popcounts over N samples.
REQ-014 The block SHALL have port out_bubble, output, width 1, set when any sample in the measurement is a non-thermometer code.
REQ-015 The block SHALL have port out_ovf, output, width 1, set when any sample in the measurement is all ones (popcount = dl_len).

Function
REQ-016 dl_tap SHALL pass through a free-running two-flop synchronizer (sync1, then sync2) on every clk_capture edge, independent of state.
REQ-017 The FSM SHALL have the states IDLE, FILL0, FILL1, ACCUM and DONE.
REQ-018 In IDLE with en=1 and arm=1, the FSM SHALL go to FILL0, clear the accumulator, sample counter and flags, and latch N from n_sel.
REQ-019 arm SHALL be ignored in every state other than IDLE.
REQ-020 FILL0 SHALL go to FILL1, and FILL1 SHALL go to ACCUM, unconditionally.
REQ-021 On each edge in ACCUM, the block SHALL add popcount(sync2) to the accumulator and increment the counter.
REQ-022 When the counter reaches N-1, the FSM SHALL go to DONE on the same edge, after the final add.
REQ-023 On each edge in ACCUM, out_bubble SHALL be set if any index i has sync2[i+1]=1 and sync2[i]=0, and out_ovf SHALL be set if sync2 is all ones.
REQ-024 out_valid SHALL be high only in DONE.
REQ-025 out_valid SHALL rise N+2 edges after the edge that accepted arm.
REQ-026 In DONE, out_sum, out_bubble and out_ovf SHALL be held stable.
REQ-027 DONE SHALL go to IDLE on an edge where out_ready=1; if out_ready=1 is already high on entry to DONE, the transfer SHALL complete on the next edge.
REQ-028 out_valid SHALL NOT depend combinationally on out_ready.
REQ-029 The accumulator SHALL be acc_w bits wide, and the maximum sum 8*dl_len SHALL fit without wrap.
REQ-030 en=0 in any state other than DONE SHALL force IDLE on the next edge and discard the partial result.
REQ-031 en=0 in DONE SHALL NOT drop out_valid until the handshake completes.
REQ-032 When en=0 arrives together with any other condition in the same cycle, en=0 SHALL take priority except in DONE.

Reset
REQ-033 Assertion of rst_n=0 SHALL immediately set the state to IDLE and set busy, out_valid, out_sum, out_bubble, out_ovf, the counter, sync1 and sync2 to 0, including in the middle of a measurement.
REQ-034 Release of rst_n SHALL take effect on the first clk_capture edge with rst_n=1, and arm SHALL be accepted on that edge.

Structure
REQ-035 The FSM state enum and the n_sel encoding enum SHALL live in tdc_wrapper_pkg.
REQ-036 The block SHALL contain one combinational sub-module, tt_tdc_popcount, with inputs taps[dl_len] and outputs count[len_pop_out+1], bubble and all_ones.
REQ-037 Synchronizer flops SHALL carry a keep attribute so they are not retimed or merged.

Verification
REQ-038 With n_sel=0, dl_tap=0x0000_0000_0000_00FF held and an arm pulse, the bench SHALL see out_valid three edges later, out_sum=8 and both flags at 0.
REQ-039 With n_sel=3 and dl_tap held at 0x0000_0000_0000_FFFF, the bench SHALL see out_sum=128.
REQ-040 With n_sel=3 and dl_tap all ones, the bench SHALL see out_sum=512 with no wrap and out_ovf=1.
REQ-041 With dl_tap=0x0000_0000_0000_00F7 (hole at bit 3), the bench SHALL see out_bubble=1 and out_sum=7 per sample.
REQ-042 With out_ready held 0 for 5 cycles in DONE and a second arm pulse, the bench SHALL see out_valid and out_sum stable and the arm ignored, then IDLE one edge after out_ready=1.
REQ-043 With rst_n pulsed low during ACCUM, or en dropped in FILL1, the bench SHALL see the state return to IDLE with all outputs 0 and no out_valid.
